// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared 20-bit work RAM and the hardware register window.
// Port 0 (core) has fixed priority; port 1 (loader/DMA) has a starvation guard and a bounded lock.
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 20,
    parameter int MAX_WAIT = 7,
    parameter int MAX_LOCK = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [6:0]    reg_index,
    output logic          reg_read,
    output logic          reg_write,
    output logic [15:0]   reg_wdata,
    input  logic [15:0]   reg_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 2);

    typedef enum logic [1:0] {ARB, LOCKED, COOLDOWN} state_t;

    state_t         r_state, w_next;
    logic [WW-1:0]  r_wait_cnt;
    logic [LW-1:0]  r_lock_cnt;
    logic           r_rvalid;
    logic           r_resp_port;
    logic           r_resp_hit;

    logic           w_gnt0, w_gnt1, w_gnt, w_we, w_win;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_wdata;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ARB;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB:      if (w_gnt1 && p1_lock) w_next = LOCKED;
            LOCKED: begin
                if (!p1_lock)                            w_next = ARB;
                else if (r_lock_cnt == LW'(MAX_LOCK))    w_next = COOLDOWN;
            end
            COOLDOWN: w_next = ARB;
            default:  w_next = ARB;
        endcase
    end

    // Grant logic; gated by reset_n so nothing is granted while reset is held
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n) begin
            case (r_state)
                ARB: begin
                    if (p1_req && (!p0_req || r_wait_cnt == WW'(MAX_WAIT))) w_gnt1 = 1'b1;
                    else                                                    w_gnt0 = p0_req;
                end
                LOCKED:   w_gnt1 = p1_req;
                COOLDOWN: begin
                    w_gnt0 = p0_req;
                    w_gnt1 = p1_req && !p0_req;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            if (r_state == LOCKED || w_gnt1 || !p1_req) r_wait_cnt <= '0;
            else if (r_wait_cnt != WW'(MAX_WAIT))       r_wait_cnt <= r_wait_cnt + 1'b1;

            if (r_state == LOCKED)     r_lock_cnt <= r_lock_cnt + 1'b1;
            else if (w_next == LOCKED) r_lock_cnt <= LW'(1);
            else                       r_lock_cnt <= '0;
        end
    end

    // Granted-port datapath mux; all zero on an idle bus cycle
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        if (w_gnt0) begin
            w_addr  = p0_addr;
            w_wdata = p0_wdata;
            w_we    = p0_we;
        end else if (w_gnt1) begin
            w_addr  = p1_addr;
            w_wdata = p1_wdata;
            w_we    = p1_we;
        end
    end

    assign w_gnt = w_gnt0 | w_gnt1;
    assign w_win = w_gnt && (w_addr[AW-1:7] == {(AW-7){1'b1}});

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign mem_we    = w_gnt && w_we && !w_win;
    assign reg_index = w_addr[6:0];
    assign reg_read  = w_win;
    assign reg_write = w_win && w_we;
    assign reg_wdata = w_wdata[15:0];

    // Response tracking: one outstanding read, tagged with owner port and window hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid    <= 1'b0;
            r_resp_port <= 1'b0;
            r_resp_hit  <= 1'b0;
        end else begin
            r_rvalid <= w_gnt && !w_we;
            if (w_gnt && !w_we) begin
                r_resp_port <= w_gnt1;
                r_resp_hit  <= w_win;
            end
        end
    end

    assign p0_rvalid = r_rvalid && !r_resp_port;
    assign p1_rvalid = r_rvalid &&  r_resp_port;

    always_comb begin
        rdata = '0;
        if (r_rvalid) rdata = r_resp_hit ? {{(DW-16){1'b0}}, reg_rdata} : mem_rdata;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous 20-bit work RAM and the hardware register window between two requesters.
- Port 0 is the processor core; port 1 is the host program loader / debug DMA.
- Port 0 has fixed priority. Port 1 has a starvation guard and a bounded burst lock.
- Accesses that fall in the register window are steered to the register bus instead of the RAM.

Parameters:
AW, 16, address width of both ports and of mem_addr
DW, 20, data word width (tag bits plus 16-bit value)
MAX_WAIT, 7, consecutive denied cycles after which a pending port-1 request beats port 0
MAX_LOCK, 32, maximum consecutive locked cycles before port 1 is forced out

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 access request
p0_we  in  1  port 0 write enable
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 granted this cycle
p0_rvalid  out  1  port 0 read data valid on rdata
p1_req  in  1  port 1 access request
p1_we  in  1  port 1 write enable
p1_lock  in  1  port 1 requests exclusive burst
p1_addr  in  AW  port 1 address
p1_wdata  in  DW  port 1 write data
p1_gnt  out  1  port 1 granted this cycle
p1_rvalid  out  1  port 1 read data valid on rdata
rdata  out  DW  read response data, shared by both ports
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DW  RAM read data, valid one cycle after the address
reg_index  out  7  hardware register index (addr[6:0])
reg_read  out  1  register window read strobe
reg_write  out  1  register window write strobe
reg_wdata  out  16  register write data (wdata[15:0])
reg_rdata  in  16  register read data, valid one cycle after reg_read

Behaviour:
- Reset values: state=ARB, wait_cnt=0, lock_cnt=0, both rvalid=0, resp_reg=0, rdata=0. All grant and strobe outputs are 0 while reset_n is low.
- Grants are combinational in the same cycle. At most one gnt is high per cycle. The request must be held until its gnt is seen.
- State ARB:
  - Grant p1 if p1_req && (!p0_req || wait_cnt==MAX_WAIT).
  - Else grant p0 if p0_req.
  - If p1 is granted with p1_lock=1: go to LOCKED and set lock_cnt=1.
- State LOCKED:
  - p0 is never granted.
  - p1 is granted whenever p1_req=1. A cycle with p1_req=0 is an idle bus cycle.
  - lock_cnt increments every cycle spent in LOCKED.
  - Exit to ARB when p1_lock=0, or when lock_cnt==MAX_LOCK.
- After a forced exit, state COOLDOWN for one cycle:
  - p0 is granted if p0_req.
  - p1 is granted only if p0_req=0, and may not relock.
  - Then return to ARB.
- wait_cnt:
  - Clears when p1 is granted or p1_req=0.
  - Otherwise increments, saturating at MAX_WAIT.
  - Holds at 0 in LOCKED.
- Register window is addr[15:7]==9'h1FF.
  - Window access: reg_read=1 for every granted access; reg_write=gnt&&we; mem_we=0.
  - RAM access: mem_we=gnt&&we.
- mem_addr/mem_wdata follow the granted port's addr/wdata. They are 0 when nothing is granted.
- Read response:
  - A granted read (we=0) raises that port's rvalid for exactly one cycle, one cycle later.
  - resp_reg records the port and whether the access hit the register window.
  - rdata = {4'b0, reg_rdata} for a register hit, else mem_rdata. rdata is 0 when neither rvalid is high.
- Granted writes produce no rvalid. A write in a window location performs no RAM write.
- Back-to-back reads from alternating ports each get their own rvalid. A response and a new grant may occur in the same cycle.
- Reset asserted mid-burst or with a pending response:
  - Immediately drops to ARB.
  - The pending rvalid is discarded.
  - No stray mem_we or reg_write.

Test Plan:
- Both ports request reads continuously, p0 at addr 0x0010, p1 at 0x0020 → p0 granted 7 cycles, p1 granted on the 8th, pattern repeats. Each rvalid is one cycle after its grant with the correct RAM word.
- p1 locked burst of 4 writes (0x0100–0x0103, data 0xA0001–0xA0004), p0 requesting throughout → p0_gnt low for 4 cycles. RAM holds the data. p0 granted the cycle after p1_lock drops.
- p1_lock held 40 cycles with p0 requesting → forced exit after 32 locked cycles. p0 granted in the COOLDOWN cycle. p1 regranted next cycle only via ARB rules.
- p0 write of 0x00055 to 0xFF85, then read of 0xFF85 with reg_rdata=0xBEEF → reg_write=1, reg_index=5, reg_wdata=0x0055, mem_we=0. Read returns rdata=0x0BEEF with p0_rvalid.
- reset_n pulsed low during a locked p1 read → no rvalid after reset. State ARB, wait_cnt=0. First post-reset p0 request granted immediately.
- No requests for 10 cycles → mem_we, reg_read, reg_write, both gnt and both rvalid stay 0. mem_addr=0.
